// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
package cam_cfg_pkg;

  localparam int unsigned TIMER_W  = 16;
  localparam logic [7:0]  DLY_MARK = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    PWRUP,
    FETCH,
    DECODE,
    SEND,
    RELEASE,
    DELAY,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    TMR_HOLD,
    TMR_CLR,
    TMR_LOAD,
    TMR_INC,
    TMR_DEC
  } tmr_op_e;

  // Delay words give a cycle count; DELAY exits when the down-counter reaches 0.
  function automatic logic [TIMER_W-1:0] dly_load(input logic [TIMER_W-1:0] n);
    return (n == '0) ? '0 : n - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/cam_cfg_timer.sv
// Shared 16-bit saturating timer: clear, load, count up or count down.
module cam_cfg_timer
  import cam_cfg_pkg::*;
(
  input  logic               clk_20k,
  input  logic               rst_100,
  input  tmr_op_e            op_i,
  input  logic [TIMER_W-1:0] load_i,
  input  logic [TIMER_W-1:0] cmp_i,
  output logic               term_c_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case (op_i)
      TMR_CLR:  cnt_d = '0;
      TMR_LOAD: cnt_d = load_i;
      TMR_INC:  if (cnt_q != '1) cnt_d = cnt_q + TIMER_W'(1);
      TMR_DEC:  if (cnt_q != '0) cnt_d = cnt_q - TIMER_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_20k) begin
    if (rst_100) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign term_c_o = (cnt_q == cmp_i);

endmodule

// File: rtl/cam_cfg_seq.sv
// Walks the camera config table, hands each word to the I2C sender and
// inserts power-up, inter-word and table-driven delays.
module cam_cfg_seq
  import cam_cfg_pkg::*;
#(
  parameter int unsigned LUT_SIZE    = 64,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned PWRUP_CYC   = 400,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic             clk_20k,
  input  logic             rst_100,
  input  logic             start,
  output logic [IDX_W-1:0] table_idx,
  input  logic [31:0]      table_data,
  output logic [31:0]      cfg_data,
  output logic             i2c_req,
  input  logic             i2c_ack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One extra index bit so LUT_SIZE == 2**IDX_W never wraps back to 0.
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [31:0]        cfg_q, cfg_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               resend_q, resend_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  tmr_op_e            tmr_op;
  logic [TIMER_W-1:0] tmr_cmp;
  logic               tmr_term;
  logic               ack_ok, timeout;

  assign tmr_cmp = (state_q == PWRUP)   ? TIMER_W'(PWRUP_CYC - 1)   :
                   (state_q == SEND)    ? TIMER_W'(TIMEOUT_CYC - 1) :
                   (state_q == RELEASE) ? TIMER_W'(GAP_CYC - 1)     : '0;

  // The timeout only runs while the request is actually visible to the sender.
  assign ack_ok  = i2c_ack & req_q;
  assign timeout = req_q & tmr_term;

  cam_cfg_timer u_timer (
    .clk_20k  (clk_20k),
    .rst_100  (rst_100),
    .op_i     (tmr_op),
    .load_i   (dly_load(table_data[15:0])),
    .cmp_i    (tmr_cmp),
    .term_c_o (tmr_term)
  );

  always_ff @(posedge clk_20k) begin
    if (rst_100) state_q <= PWRUP;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = PWRUP;
    end else begin
      case (state_q)
        IDLE:    state_d = PWRUP;
        PWRUP:   if (tmr_term) state_d = FETCH;
        FETCH:   state_d = DECODE;
        DECODE: begin
          if (idx_q == CNT_W'(LUT_SIZE))           state_d = DONE;
          else if (table_data[31:24] == DLY_MARK) state_d = DELAY;
          else                                    state_d = SEND;
        end
        SEND:    if (ack_ok || timeout) state_d = RELEASE;
        RELEASE: if (tmr_term) state_d = FETCH;
        DELAY:   if (tmr_term) state_d = FETCH;
        DONE:    state_d = DONE;
        default: state_d = PWRUP;
      endcase
    end
  end

  always_comb begin
    idx_d    = idx_q;
    cfg_d    = cfg_q;
    retry_d  = retry_q;
    resend_d = resend_q;
    err_d    = err_q;
    tmr_op   = TMR_HOLD;
    case (state_q)
      PWRUP: begin
        if (tmr_term) tmr_op = TMR_CLR;
        else          tmr_op = TMR_INC;
      end
      DECODE: begin
        if (idx_q != CNT_W'(LUT_SIZE)) begin
          if (table_data[31:24] == DLY_MARK) begin
            tmr_op = TMR_LOAD;
          end else begin
            cfg_d  = table_data;
            tmr_op = TMR_CLR;
          end
        end
      end
      SEND: begin
        if (ack_ok) begin
          retry_d  = '0;
          resend_d = 1'b0;
          tmr_op   = TMR_CLR;
        end else if (timeout) begin
          tmr_op = TMR_CLR;
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d  = retry_q + RTY_W'(1);
            resend_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            retry_d  = '0;
            resend_d = 1'b0;
          end
        end else if (req_q) begin
          tmr_op = TMR_INC;
        end
      end
      RELEASE: begin
        if (tmr_term) begin
          tmr_op = TMR_CLR;
          if (!resend_q) idx_d = idx_q + CNT_W'(1);
        end else begin
          tmr_op = TMR_INC;
        end
      end
      DELAY: begin
        if (tmr_term) idx_d = idx_q + CNT_W'(1);
        else          tmr_op = TMR_DEC;
      end
      default: tmr_op = TMR_HOLD;
    endcase
    if (start) begin
      idx_d    = '0;
      cfg_d    = '0;
      retry_d  = '0;
      resend_d = 1'b0;
      err_d    = 1'b0;
      tmr_op   = TMR_CLR;
    end
    // Request rises one cycle after cfg_data loads and drops on the exit edge.
    req_d  = (state_q == SEND) && (state_d == SEND);
    busy_d = !((state_d == IDLE) || (state_d == DONE));
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_20k) begin
    if (rst_100) begin
      idx_q    <= '0;
      cfg_q    <= '0;
      retry_q  <= '0;
      resend_q <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      cfg_q    <= cfg_d;
      retry_q  <= retry_d;
      resend_q <= resend_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign table_idx = idx_q[IDX_W-1:0];
  assign cfg_data  = cfg_q;
  assign i2c_req   = req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Bench for cam_cfg_seq: registered table model, I2C ack model with
// selectable silent pulses, and a pulse scoreboard (word, width, gap).
module tb_cam_cfg_seq;

  localparam int unsigned LUT_SIZE    = 3;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned PWRUP_CYC   = 400;
  localparam int unsigned GAP_CYC     = 4;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned MAX_RETRY   = 2;

  localparam int ACK_LAT  = 42;
  localparam int ACK_LEN  = ACK_LAT + 1;          // ack is acted on one edge after it rises
  localparam int TO_LEN   = int'(TIMEOUT_CYC);
  localparam int WORD_CYC = 3 + ACK_LEN + int'(GAP_CYC);  // FETCH+DECODE+SEND setup, pulse, gap
  localparam int DLY_N    = 100;
  localparam int DLY_GAP  = int'(GAP_CYC) + 2 + DLY_N + 3;
  localparam int DONE_3W  = int'(PWRUP_CYC) + 3 * WORD_CYC + 2;
  localparam int DONE_DLY = int'(PWRUP_CYC) + 2 * WORD_CYC + (2 + DLY_N) + 2;

  localparam logic [31:0] W0   = 32'h4212_8000;
  localparam logic [31:0] W1   = 32'h4211_0100;
  localparam logic [31:0] W2   = 32'h426B_4A00;
  localparam logic [31:0] WDLY = 32'hFE00_0064;

  logic             clk_20k = 1'b0;
  logic             rst_100;
  logic             start;
  logic [IDX_W-1:0] table_idx;
  logic [31:0]      table_data;
  logic [31:0]      cfg_data;
  logic             i2c_req;
  logic             i2c_ack = 1'b0;
  logic             busy;
  logic             done;
  logic             err;

  int checks   = 0;
  int failures = 0;

  cam_cfg_seq #(
    .LUT_SIZE    (LUT_SIZE),
    .IDX_W       (IDX_W),
    .PWRUP_CYC   (PWRUP_CYC),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk_20k    (clk_20k),
    .rst_100    (rst_100),
    .start      (start),
    .table_idx  (table_idx),
    .table_data (table_data),
    .cfg_data   (cfg_data),
    .i2c_req    (i2c_req),
    .i2c_ack    (i2c_ack),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk_20k = ~clk_20k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Table with one cycle of read latency.
  logic [31:0] rom [0:2];
  always @(posedge clk_20k)
    table_data <= (table_idx < 8'd3) ? rom[table_idx[1:0]] : 32'h0;

  // Sender model: acks ACK_LAT edges after req rises unless the pulse is silenced.
  int   mdl_pulse = 0;
  int   hi_cnt    = 0;
  logic silent    = 1'b0;
  int   sil_lo    = -1;
  int   sil_hi    = -1;
  always @(posedge clk_20k) begin
    if (!i2c_req) begin
      if (hi_cnt != 0) mdl_pulse <= mdl_pulse + 1;
      hi_cnt  <= 0;
      i2c_ack <= 1'b0;
    end else begin
      if (hi_cnt == 0) silent <= (mdl_pulse >= sil_lo) && (mdl_pulse < sil_hi);
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt == ACK_LAT - 1 && !silent) i2c_ack <= 1'b1;
    end
  end

  typedef struct {
    logic [31:0] cfg;
    int          len;
    int          gap;
  } pulse_t;

  pulse_t exp_q[$];

  task automatic push(input logic [31:0] cfg, input int len, input int gap);
    pulse_t p;
    p.cfg = cfg;
    p.len = len;
    p.gap = gap;
    exp_q.push_back(p);
  endtask

  // Scoreboard: every req pulse is matched against the next expected entry.
  logic        req_prev = 1'b0;
  int          hi_len = 0, lo_len = 0, gap_at_rise = 0;
  logic [31:0] cfg_rise = '0, cfg_last = '0;
  always @(negedge clk_20k) begin
    pulse_t e;
    if (i2c_req) begin
      if (!req_prev) begin
        cfg_rise    = cfg_data;
        gap_at_rise = lo_len;
        hi_len      = 0;
      end
      hi_len++;
      cfg_last = cfg_data;
    end else begin
      if (req_prev) begin
        chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pulse_cfg", cfg_rise, e.cfg);
          chk("cfg_stable", cfg_last, cfg_rise);
          chk("pulse_len", 32'(hi_len), 32'(e.len));
          if (e.gap > 0) chk("pulse_gap", 32'(gap_at_rise), 32'(e.gap));
        end
        lo_len = 0;
      end
      lo_len++;
    end
    req_prev = i2c_req;
  end

  task automatic wait_req(input logic lvl, input int max, input string tag);
    int n = 0;
    while (i2c_req !== lvl && n < max) begin
      @(negedge clk_20k);
      n++;
    end
    chk(tag, 32'(i2c_req), 32'(lvl));
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin
      @(negedge clk_20k);
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_20k);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idx"},  32'(table_idx), 32'd0);
    chk({tag, "_cfg"},  cfg_data, 32'd0);
    chk({tag, "_req"},  32'(i2c_req), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int cyc;
    int p;
    rom     = '{W0, W1, W2};
    rst_100 = 1'b1;
    start   = 1'b0;

    // Power-up reset, then three plain words.
    repeat (3) @(posedge clk_20k);
    @(negedge clk_20k);
    chk_reset_vals("rst");
    rst_100 = 1'b0;
    push(W0, ACK_LEN, 0);
    push(W1, ACK_LEN, 0);
    push(W2, ACK_LEN, 0);
    wait_done(3000, cyc);
    chk("done_latency", 32'(cyc), 32'(DONE_3W));
    chk("plain_err", 32'(err), 32'd0);
    chk("plain_busy", 32'(busy), 32'd0);
    chk("plain_idx_end", 32'(table_idx), 32'(LUT_SIZE));
    chk("plain_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk_20k);
    chk("done_hold", 32'(done), 32'd1);
    chk("cfg_hold", cfg_data, W2);

    // Delay marker between two words.
    rom = '{W0, WDLY, W2};
    push(W0, ACK_LEN, 0);
    push(W2, ACK_LEN, DLY_GAP);
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    wait_req(1'b1, 1000, "dly_w0_rise");
    wait_req(1'b0, 1000, "dly_w0_fall");
    wait_req(1'b1, 1000, "dly_w2_rise");
    chk("dly_idx_past_marker", 32'(table_idx), 32'd2);
    wait_done(1000, cyc);
    chk("dly_sb_empty", 32'(exp_q.size()), 32'd0);

    // Word 1 never acknowledged; start aborts the following word mid-SEND.
    rom    = '{W0, W1, W2};
    p      = mdl_pulse;
    sil_lo = p + 1;
    sil_hi = p + 4;
    push(W0, ACK_LEN, 0);
    push(W1, TO_LEN, 0);
    push(W1, TO_LEN, 0);
    push(W1, TO_LEN, 0);
    push(W2, 1, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_req(1'b1, 1000, "nack_rise");
      wait_req(1'b0, 1000, "nack_fall");
    end
    chk("nack_err", 32'(err), 32'd1);
    wait_req(1'b1, 1000, "nack_w2_rise");
    chk("nack_idx_adv", 32'(table_idx), 32'd2);
    chk("nack_err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("abort_req", 32'(i2c_req), 32'd0);
    chk("abort_idx", 32'(table_idx), 32'd0);
    chk("abort_err_clr", 32'(err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    push(W0, ACK_LEN, 0);
    push(W1, ACK_LEN, 0);
    push(W2, ACK_LEN, 0);
    wait_done(3000, cyc);
    chk("replay_err", 32'(err), 32'd0);
    chk("replay_sb_empty", 32'(exp_q.size()), 32'd0);

    // Word 1 silent on its first attempt only.
    p      = mdl_pulse;
    sil_lo = p + 1;
    sil_hi = p + 2;
    push(W0, ACK_LEN, 0);
    push(W1, TO_LEN, 0);
    push(W1, ACK_LEN, 0);
    push(W2, ACK_LEN, 0);
    pulse_start();
    wait_done(3000, cyc);
    chk("retry1_err", 32'(err), 32'd0);
    chk("retry1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset held during DELAY.
    rom = '{W0, WDLY, W2};
    push(W0, ACK_LEN, 0);
    pulse_start();
    wait_req(1'b1, 1000, "rstdly_w0_rise");
    wait_req(1'b0, 1000, "rstdly_w0_fall");
    repeat (20) @(negedge clk_20k);
    chk("in_delay_idx", 32'(table_idx), 32'd1);
    chk("in_delay_req", 32'(i2c_req), 32'd0);
    rst_100 = 1'b1;
    @(negedge clk_20k);
    chk_reset_vals("rstdly");
    repeat (4) @(negedge clk_20k);
    rst_100 = 1'b0;
    push(W0, ACK_LEN, 0);
    push(W2, ACK_LEN, DLY_GAP);
    wait_done(3000, cyc);
    chk("rstdly_latency", 32'(cyc), 32'(DONE_DLY));
    chk("rstdly_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset and start together in the middle of a transfer.
    rom = '{W0, W1, W2};
    push(W0, 1, 0);
    pulse_start();
    wait_req(1'b1, 1000, "both_w0_rise");
    rst_100 = 1'b1;
    start   = 1'b1;
    @(negedge clk_20k);
    rst_100 = 1'b0;
    start   = 1'b0;
    chk_reset_vals("both");
    push(W0, ACK_LEN, 0);
    push(W1, ACK_LEN, 0);
    push(W2, ACK_LEN, 0);
    wait_done(3000, cyc);
    chk("both_latency", 32'(cyc), 32'(DONE_3W));
    chk("both_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
